fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl_sat_counter16.sv | 22 ++
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encodings, boot delay default
// and the saturating-increment helper used by the event counters.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } fetch_state_e;

  localparam int unsigned BOOT_CYCLES_DEFAULT = 4;
  localparam int unsigned CNT_W               = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of hazard/redirect inputs and PC / IF-ID control outputs between the
// pipeline and the fetch controller.
interface fetch_ctrl_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        load_use;
  logic        imem_ready;
  logic        halt;
  logic        resume;

  logic        PCSrc;
  logic        PC_write;
  logic [31:0] PC_Branch;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        fetch_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output branch_taken, branch_target, load_use, imem_ready, halt, resume,
    input  PCSrc, PC_write, PC_Branch, IF_ID_write, IF_ID_flush, ID_EX_flush,
           fetch_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_taken, branch_target, load_use, imem_ready, halt, resume,
    output PCSrc, PC_write, PC_Branch, IF_ID_write, IF_ID_flush, ID_EX_flush,
           fetch_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable) begin
      value <= sat_inc(value);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: boot hold-off, branch redirect, memory/load-use stalls
// and halt/resume, with a one-entry pending-redirect register.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = BOOT_CYCLES_DEFAULT
)
(
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  fetch_state_e      state, state_nxt;
  logic [BOOT_W-1:0] boot_cnt, boot_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [31:0]       pend_target, pend_target_nxt;
  logic              stall_inc, flush_inc;

  always_comb begin
    bus.PCSrc       = 1'b0;
    bus.PC_write    = 1'b0;
    bus.PC_Branch   = '0;
    bus.IF_ID_write = 1'b0;
    bus.IF_ID_flush = 1'b0;
    bus.ID_EX_flush = 1'b0;
    bus.fetch_valid = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    state_nxt       = state;
    boot_nxt        = boot_cnt;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;

    case (state)
      BOOT: begin
        if (boot_cnt == '0) state_nxt = RUN;
        else                boot_nxt  = boot_cnt - 1'b1;
      end

      RUN: begin
        if (bus.halt) begin
          state_nxt = HALT;
          if (bus.branch_taken) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = bus.branch_target;
          end
        end else if (bus.branch_taken) begin
          bus.IF_ID_flush = 1'b1;
          bus.ID_EX_flush = 1'b1;
          if (bus.imem_ready) begin
            bus.PCSrc     = 1'b1;
            bus.PC_Branch = bus.branch_target;
            bus.PC_write  = 1'b1;
            flush_inc     = 1'b1;
          end else begin
            stall_inc       = 1'b1;
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = bus.branch_target;
            state_nxt       = WAIT_MEM;
          end
        end else if (!bus.imem_ready) begin
          stall_inc = 1'b1;
          state_nxt = WAIT_MEM;
        end else if (bus.load_use) begin
          bus.ID_EX_flush = 1'b1;
          bus.fetch_valid = 1'b1;
          stall_inc       = 1'b1;
        end else begin
          bus.PC_write    = 1'b1;
          bus.IF_ID_write = 1'b1;
          bus.fetch_valid = 1'b1;
        end
      end

      WAIT_MEM: begin
        if (!bus.imem_ready) begin
          stall_inc = 1'b1;
          if (bus.branch_taken) begin
            bus.IF_ID_flush = 1'b1;
            bus.ID_EX_flush = 1'b1;
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = bus.branch_target;
          end
        end else if (bus.branch_taken || pend_valid) begin
          // A branch resolving in the very cycle memory returns is newer than the pending one.
          bus.PCSrc       = 1'b1;
          bus.PC_Branch   = bus.branch_taken ? bus.branch_target : pend_target;
          bus.PC_write    = 1'b1;
          bus.IF_ID_flush = 1'b1;
          bus.ID_EX_flush = bus.branch_taken;
          flush_inc       = 1'b1;
          pend_valid_nxt  = 1'b0;
          pend_target_nxt = '0;
          state_nxt       = RUN;
        end else begin
          bus.PC_write    = 1'b1;
          bus.IF_ID_write = 1'b1;
          bus.fetch_valid = 1'b1;
          state_nxt       = RUN;
        end
      end

      HALT: begin
        if (bus.branch_taken) begin
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = bus.branch_target;
        end
        if (bus.resume && !bus.halt) begin
          state_nxt = (pend_valid || bus.branch_taken) ? WAIT_MEM : RUN;
        end
      end

      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      boot_cnt    <= BOOT_W'(BOOT_CYCLES - 1);
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      boot_cnt    <= boot_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (stall_inc),
    .clear  (state == BOOT),
    .value  (bus.stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (flush_inc),
    .clear  (state == BOOT),
    .value  (bus.flush_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues hand-computed expectations per
// cycle, the negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.BOOT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ctl order: {PCSrc, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, fetch_valid}
  localparam logic [5:0] Z   = 6'b000000;
  localparam logic [5:0] N   = 6'b011001;
  localparam logic [5:0] BR  = 6'b110110;
  localparam logic [5:0] BRW = 6'b110100;
  localparam logic [5:0] FL  = 6'b000110;
  localparam logic [5:0] LU  = 6'b000011;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] pcb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/ctl"}, 32'({bus.PCSrc, bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush,
                              bus.ID_EX_flush, bus.fetch_valid}), 32'(e.ctl));
      check({t, "/PC_Branch"}, bus.PC_Branch, e.pcb);
      check({t, "/stall_cnt"}, 32'(bus.stall_cnt), 32'(e.sc));
      check({t, "/flush_cnt"}, 32'(bus.flush_cnt), 32'(e.fc));
    end
  end

  task automatic cyc(input string tag, input logic bt, input logic [31:0] tgt,
                     input logic lu, input logic rdy, input logic hl, input logic rs,
                     input logic [5:0] ctl, input logic [31:0] pcb,
                     input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.load_use      = lu;
    bus.imem_ready    = rdy;
    bus.halt          = hl;
    bus.resume        = rs;
    e.ctl = ctl;
    e.pcb = pcb;
    e.sc  = sc;
    e.fc  = fc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Reset with distracting inputs, then exactly four silent boot cycles.
  task automatic do_reset();
    reset = 1'b0;
    cyc("rst0", 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, Z, 32'h0, 16'h0, 16'h0);
    cyc("rst1", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, Z, 32'h0, 16'h0, 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc("boot", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, Z, 32'h0, 16'h0, 16'h0);
  endtask

  initial begin
    reset             = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.load_use      = 1'b0;
    bus.imem_ready    = 1'b0;
    bus.halt          = 1'b0;
    bus.resume        = 1'b0;
    @(posedge clk);
    #1;

    // boot release, taken branch with memory ready, load-use bubble
    do_reset();
    cyc("run0",    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, N,  32'h0,   16'd0, 16'd0);
    cyc("br100",   1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, BR, 32'h100, 16'd0, 16'd0);
    cyc("post_br", 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, N,  32'h0,   16'd0, 16'd1);
    cyc("lu",      1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, LU, 32'h0,   16'd0, 16'd1);
    cyc("post_lu", 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, N,  32'h0,   16'd1, 16'd1);

    // branch during memory stall, newer branch overwrites pending target
    do_reset();
    cyc("wm_br200", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, FL,  32'h0,   16'd0, 16'd0);
    cyc("wm_br300", 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, FL,  32'h0,   16'd1, 16'd0);
    cyc("wm_stall", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, Z,   32'h0,   16'd2, 16'd0);
    cyc("wm_apply", 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, BRW, 32'h300, 16'd3, 16'd0);
    cyc("wm_post",  1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, N,   32'h0,   16'd3, 16'd1);

    // halt / resume with redirects latched in HALT and in RUN+halt
    do_reset();
    cyc("halt",       1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, Z,   32'h0,   16'd0, 16'd0);
    cyc("h_br400",    1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, Z,   32'h0,   16'd0, 16'd0);
    cyc("h_idle",     1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, Z,   32'h0,   16'd0, 16'd0);
    cyc("h_both",     1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, Z,   32'h0,   16'd0, 16'd0);
    cyc("h_resume",   1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, Z,   32'h0,   16'd0, 16'd0);
    cyc("h_apply",    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, BRW, 32'h400, 16'd0, 16'd0);
    cyc("h_post",     1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, N,   32'h0,   16'd0, 16'd1);
    cyc("halt_br600", 1'b1, 32'h600, 1'b0, 1'b1, 1'b1, 1'b0, Z,   32'h0,   16'd0, 16'd1);
    cyc("h_resume2",  1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, Z,   32'h0,   16'd0, 16'd1);
    cyc("h_apply2",   1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, BRW, 32'h600, 16'd0, 16'd1);
    cyc("halt3",      1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, Z,   32'h0,   16'd0, 16'd2);
    cyc("h_br500",    1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, Z,   32'h0,   16'd0, 16'd2);

    // reset inside HALT drops the pending redirect
    do_reset();
    cyc("no_redir", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, N, 32'h0, 16'd0, 16'd0);

    // long memory stall saturates stall_cnt
    bus.imem_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    cyc("sat",      1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z, 32'h0, 16'hFFFF, 16'd0);
    cyc("sat_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Z, 32'h0, 16'hFFFF, 16'd0);
    cyc("sat_exit", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, N, 32'h0, 16'hFFFF, 16'd0);

    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
